systolic_pe_dual: RTL and testbench

//  Second-generation processing element for the 2D systolic array multiplier; one instance per array cell.

---
 rtl/systolic_pkg.sv | 52 +++++
 rtl/systolic_pe_dual_mac.sv | 52 +++++
 rtl/systolic_pe_dual.sv | 185 ++++++++++++++++++
 tb/tb_systolic_pe_dual.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the dual-mode systolic processing element.
// The saturating adder is only called when PE_ACC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COMP  = 2'd2,
        DRAIN = 2'd3
    } pe_state_e;

    typedef enum logic {
        PE_MODE_OS = 1'b0,
        PE_MODE_WS = 1'b1
    } pe_mode_e;

    // Widest accumulator the saturating adder can handle.
    localparam int SAT_W = 64;

    // Adds two w-bit values (zero-padded to SAT_W) and clamps to the w-bit
    // signed or unsigned range. Returns {clamped, result}.
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] x,
        input logic [SAT_W-1:0] y,
        input int               w,
        input logic             sgn
    );
        logic [SAT_W:0]   raw;
        logic [SAT_W-1:0] mask;
        logic [SAT_W-1:0] res;
        logic [5:0]       msb;
        logic [6:0]       cout;
        logic             ovf;
        raw  = {1'b0, x} + {1'b0, y};
        mask = (64'd1 << w) - 64'd1;
        res  = raw[SAT_W-1:0] & mask;
        msb  = 6'(w - 1);
        cout = 7'(w);
        ovf  = 1'b0;
        if (sgn) begin
            if ((x[msb] == y[msb]) && (res[msb] != x[msb])) begin
                ovf = 1'b1;
                res = x[msb] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
            end
        end else if (raw[cout]) begin
            ovf = 1'b1;
            res = mask;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/systolic_pe_dual_mac.sv
// Combinational extend-multiply-add shared by the OS accumulate and WS psum paths.
// PE_ACC_SAT_EN defined: the add clamps to the ACC_W range and ovf flags a clamp.
module pe_mac
    import systolic_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
)(
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int P_W = A_W + B_W;

    logic [ACC_W-1:0] prod_ext;

    // The full product always fits in A_W+B_W bits; extension to the
    // accumulator width follows the operand signedness.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [P_W-1:0] a_s;
            logic signed [P_W-1:0] b_s;
            logic signed [P_W-1:0] prod;
            assign a_s      = P_W'($signed(a));
            assign b_s      = P_W'($signed(b));
            assign prod     = a_s * b_s;
            assign prod_ext = ACC_W'(prod);
        end else begin : g_unsigned
            logic [P_W-1:0] prod;
            assign prod     = P_W'(a) * P_W'(b);
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

`ifdef PE_ACC_SAT_EN
    logic [SAT_W:0] sat_res;
    logic           unused_hi;
    assign sat_res   = sat_add(SAT_W'(addend), SAT_W'(prod_ext), ACC_W, SIGNED != 0);
    assign sum       = sat_res[ACC_W-1:0];
    assign ovf       = sat_res[SAT_W];
    assign unused_hi = ^sat_res[SAT_W-1:ACC_W];
`else
    assign sum = addend + prod_ext;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/systolic_pe_dual.sv
// Dual-dataflow (output-stationary / weight-stationary) systolic array cell.
// Optional feature macro: PE_ACC_SAT_EN (saturating accumulate, sticky acc_ovf).
module systolic_pe_dual
    import systolic_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             load_en,
    input  logic             compute_en,
    input  logic             drain_en,
    input  logic             clear_acc,
    input  logic [A_W-1:0]   a_in,
    input  logic             a_in_vld,
    input  logic [B_W-1:0]   b_in,
    input  logic             b_in_vld,
    input  logic [ACC_W-1:0] psum_in,
    input  logic             psum_in_vld,
    output logic [A_W-1:0]   a_out,
    output logic             a_out_vld,
    output logic [B_W-1:0]   b_out,
    output logic             b_out_vld,
    output logic [ACC_W-1:0] psum_out,
    output logic             psum_out_vld,
    output logic             busy,
    output logic             acc_ovf
);

    generate
        if (ACC_W < A_W + B_W) begin : g_bad_acc_w
            $error("systolic_pe_dual: ACC_W must be at least A_W+B_W");
        end
        if (ACC_W >= SAT_W) begin : g_acc_too_wide
            $error("systolic_pe_dual: ACC_W must be below 64");
        end
    endgenerate

    pe_state_e        state;
    pe_state_e        next_state;
    pe_mode_e         mode_q;
    logic [ACC_W-1:0] acc;
    logic [A_W-1:0]   w_stat;
    logic             drain_first;
    logic [A_W-1:0]   mac_a;
    logic [ACC_W-1:0] mac_add;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_ovf;
    logic             os_mac;
    logic             ws_mac;

    // One multiplier serves both dataflows: OS multiplies the streamed a with b
    // into acc, WS multiplies the stationary weight with b into the psum chain.
    assign mac_a   = (mode_q == PE_MODE_WS) ? w_stat : a_in;
    assign mac_add = (mode_q == PE_MODE_WS) ? psum_in : acc;
    assign os_mac  = (state == COMP) && (mode_q == PE_MODE_OS) && a_in_vld && b_in_vld;
    assign ws_mac  = (state == COMP) && (mode_q == PE_MODE_WS) && psum_in_vld && b_in_vld;
    assign busy    = (state != IDLE);

    pe_mac #(
        .A_W    (A_W),
        .B_W    (B_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a      (mac_a),
        .b      (b_in),
        .addend (mac_add),
        .sum    (mac_sum),
        .ovf    (mac_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: the highest-priority request wins in IDLE, and if that request
    // is not legal in the current mode the cell simply stays idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (drain_en) begin
                    next_state = (pe_mode_e'(mode) == PE_MODE_OS) ? DRAIN : IDLE;
                end else if (load_en) begin
                    next_state = (pe_mode_e'(mode) == PE_MODE_WS) ? LOAD : IDLE;
                end else if (compute_en) begin
                    next_state = COMP;
                end
            end
            LOAD:    if (!load_en)    next_state = compute_en ? COMP : IDLE;
            COMP:    if (!compute_en) next_state = IDLE;
            DRAIN:   if (!drain_en)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: valids default low each cycle, data outputs hold unless the
    // active state refreshes them; clear_acc overrides any same-cycle MAC.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= PE_MODE_OS;
            acc          <= '0;
            w_stat       <= '0;
            drain_first  <= 1'b0;
            a_out        <= '0;
            a_out_vld    <= 1'b0;
            b_out        <= '0;
            b_out_vld    <= 1'b0;
            psum_out     <= '0;
            psum_out_vld <= 1'b0;
        end else begin
            a_out_vld    <= 1'b0;
            b_out_vld    <= 1'b0;
            psum_out_vld <= 1'b0;
            drain_first  <= (state != DRAIN) && (next_state == DRAIN);
            if (state == IDLE) begin
                mode_q <= pe_mode_e'(mode);
            end
            case (state)
                LOAD: begin
                    a_out     <= a_in;
                    a_out_vld <= a_in_vld;
                    if (a_in_vld) begin
                        w_stat <= a_in;
                    end
                end
                COMP: begin
                    a_out     <= a_in;
                    b_out     <= b_in;
                    b_out_vld <= b_in_vld;
                    if (mode_q == PE_MODE_OS) begin
                        a_out_vld <= a_in_vld;
                        if (os_mac) begin
                            acc <= mac_sum;
                        end
                    end else begin
                        psum_out     <= mac_sum;
                        psum_out_vld <= psum_in_vld && b_in_vld;
                    end
                end
                DRAIN: begin
                    if (drain_first) begin
                        psum_out     <= acc;
                        psum_out_vld <= 1'b1;
                    end else begin
                        psum_out     <= psum_in;
                        psum_out_vld <= psum_in_vld;
                    end
                end
                default: ;
            endcase
            if (clear_acc) begin
                acc <= '0;
            end
        end
    end

`ifdef PE_ACC_SAT_EN
    // Sticky clamp flag; only reset or clear_acc lower it.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_ovf <= 1'b0;
        end else if (clear_acc) begin
            acc_ovf <= 1'b0;
        end else if (mac_ovf && (os_mac || ws_mac)) begin
            acc_ovf <= 1'b1;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = mac_ovf;
    assign acc_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_pe_dual.sv
// Self-checking bench for systolic_pe_dual. Three instances share one stimulus:
// ACC_W=24 unsigned, ACC_W=24 signed and ACC_W=16 unsigned. Expected drain and
// psum values come from a behavioural model and are queued when driven.
// Honours PE_ACC_SAT_EN when defined at compile time.
module tb_systolic_pe_dual;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        load_en = 1'b0;
    logic        compute_en = 1'b0;
    logic        drain_en = 1'b0;
    logic        clear_acc = 1'b0;
    logic [7:0]  a_in = '0;
    logic        a_in_vld = 1'b0;
    logic [7:0]  b_in = '0;
    logic        b_in_vld = 1'b0;
    logic [23:0] psum_in = '0;
    logic        psum_in_vld = 1'b0;

    logic [7:0]  a_out, b_out, a_out_s, b_out_s, a_out_16, b_out_16;
    logic        a_out_vld, b_out_vld, a_out_vld_s, b_out_vld_s, a_out_vld_16, b_out_vld_16;
    logic [23:0] psum_out, psum_out_s;
    logic [15:0] psum_out_16;
    logic        psum_out_vld, psum_out_vld_s, psum_out_vld_16;
    logic        busy, busy_s, busy_16, acc_ovf, acc_ovf_s, acc_ovf_16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        longint e0;
        longint e1;
        longint e2;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc[3] = '{0, 0, 0};
    bit     m_ovf[3] = '{1'b0, 1'b0, 1'b0};
    int     m_w[3]   = '{24, 24, 16};
    bit     m_sgn[3] = '{1'b0, 1'b1, 1'b0};

    systolic_pe_dual #(.A_W(8), .B_W(8), .ACC_W(24), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .mode(mode), .load_en(load_en), .compute_en(compute_en),
        .drain_en(drain_en), .clear_acc(clear_acc), .a_in(a_in), .a_in_vld(a_in_vld),
        .b_in(b_in), .b_in_vld(b_in_vld), .psum_in(psum_in), .psum_in_vld(psum_in_vld),
        .a_out(a_out), .a_out_vld(a_out_vld), .b_out(b_out), .b_out_vld(b_out_vld),
        .psum_out(psum_out), .psum_out_vld(psum_out_vld), .busy(busy), .acc_ovf(acc_ovf)
    );

    systolic_pe_dual #(.A_W(8), .B_W(8), .ACC_W(24), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .mode(mode), .load_en(load_en), .compute_en(compute_en),
        .drain_en(drain_en), .clear_acc(clear_acc), .a_in(a_in), .a_in_vld(a_in_vld),
        .b_in(b_in), .b_in_vld(b_in_vld), .psum_in(psum_in), .psum_in_vld(psum_in_vld),
        .a_out(a_out_s), .a_out_vld(a_out_vld_s), .b_out(b_out_s), .b_out_vld(b_out_vld_s),
        .psum_out(psum_out_s), .psum_out_vld(psum_out_vld_s), .busy(busy_s), .acc_ovf(acc_ovf_s)
    );

    systolic_pe_dual #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(0)) dut_16 (
        .clk(clk), .reset(reset), .mode(mode), .load_en(load_en), .compute_en(compute_en),
        .drain_en(drain_en), .clear_acc(clear_acc), .a_in(a_in), .a_in_vld(a_in_vld),
        .b_in(b_in), .b_in_vld(b_in_vld), .psum_in(psum_in[15:0]), .psum_in_vld(psum_in_vld),
        .a_out(a_out_16), .a_out_vld(a_out_vld_16), .b_out(b_out_16), .b_out_vld(b_out_vld_16),
        .psum_out(psum_out_16), .psum_out_vld(psum_out_vld_16), .busy(busy_16), .acc_ovf(acc_ovf_16)
    );

    always #5 clk = ~clk;

    // Behavioural reference: interpret acc per signedness, add the exact product,
    // then clamp or wrap to w bits.
    function automatic longint model_acc(input longint acc, input logic [7:0] a, input logic [7:0] b,
                                         input bit sgn, input int w, output bit ovf);
        longint accv, ea, eb, s;
        accv = acc;
        if (sgn && (((acc >> (w - 1)) & 64'sd1) != 0)) accv = acc - (longint'(1) << w);
        if (sgn) begin
            ea = longint'($signed(a));
            eb = longint'($signed(b));
        end else begin
            ea = longint'(a);
            eb = longint'(b);
        end
        s = accv + ea * eb;
        ovf = 1'b0;
`ifdef PE_ACC_SAT_EN
        begin
            longint hi, lo;
            hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
            lo = sgn ? -(longint'(1) << (w - 1)) : 0;
            if (s > hi) begin s = hi; ovf = 1'b1; end
            else if (s < lo) begin s = lo; ovf = 1'b1; end
        end
`endif
        return s & ((longint'(1) << w) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    task automatic clear_all();
        clear_acc = 1'b1;
        tick();
        clear_acc = 1'b0;
        model_clear();
    endtask

    task automatic push_acc();
        exp_q.push_back('{m_acc[0], m_acc[1], m_acc[2]});
    endtask

    // One OS compute cycle; the model follows the DUT rule that clear_acc drops the MAC.
    task automatic os_pair(input logic [7:0] a, input logic [7:0] b, input bit vld);
        bit o;
        a_in = a;
        b_in = b;
        a_in_vld = vld;
        b_in_vld = vld;
        if (clear_acc) model_clear();
        else if (vld) begin
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = model_acc(m_acc[k], a, b, m_sgn[k], m_w[k], o);
                if (o) m_ovf[k] = 1'b1;
            end
        end
        tick();
    endtask

    task automatic start_os_compute();
        mode = 1'b0;
        compute_en = 1'b1;
        tick();
    endtask

    task automatic stop_compute();
        compute_en = 1'b0;
        os_pair(8'd0, 8'd0, 1'b0);
        tick();
    endtask

    // Single-cycle drain; waits a bounded number of cycles for the valid pulse
    // and reports whether it lasted exactly one cycle.
    task automatic run_drain(output bit got, output bit one_cycle, output logic [23:0] o0,
                             output logic [23:0] o1, output logic [15:0] o2);
        got = 1'b0;
        mode = 1'b0;
        drain_en = 1'b1;
        tick();
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (psum_out_vld) begin
                got = 1'b1;
                break;
            end
        end
        o0 = psum_out;
        o1 = psum_out_s;
        o2 = psum_out_16;
        tick();
        one_cycle = !psum_out_vld && !busy;
    endtask

    task automatic test_reset();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        exp_t e;
        reset = 1'b0;
        start_os_compute();
        os_pair(8'd37, 8'd1, 1'b1);
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, a_out_vld, b_out_vld, psum_out_vld, acc_ovf, a_out, b_out, psum_out} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_u24 got busy=%b a=%0d b=%0d psum=%0d vld=%b%b%b required all zero",
                     busy, a_out, b_out, psum_out, a_out_vld, b_out_vld, psum_out_vld);
        end
        checks++;
        if ({busy_s, a_out_vld_s, b_out_vld_s, psum_out_vld_s, acc_ovf_s, a_out_s, b_out_s, psum_out_s} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_s24 got busy=%b a=%0d b=%0d psum=%0d required all zero",
                     busy_s, a_out_s, b_out_s, psum_out_s);
        end
        checks++;
        if ({busy_16, a_out_vld_16, b_out_vld_16, psum_out_vld_16, acc_ovf_16, a_out_16, b_out_16, psum_out_16} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_u16 got busy=%b a=%0d b=%0d psum=%0d required all zero",
                     busy_16, a_out_16, b_out_16, psum_out_16);
        end
        tick();
        reset = 1'b0;
        compute_en = 1'b0;
        a_in_vld = 1'b0;
        b_in_vld = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_out_vld || b_out_vld || psum_out_vld || busy) begin
                failures++;
                $display("[TB] FAIL reset_quiet cycle %0d got vld=%b%b%b busy=%b required 0000",
                         i, a_out_vld, b_out_vld, psum_out_vld, busy);
            end
        end
        push_acc();
        run_drain(got, one, o0, o1, o2);
        e = exp_q.pop_front();
        checks++;
        if (!got || {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL reset_acc_drain got vld=%b u24=%0d s24=%0d u16=%0d required 1 %0d %0d %0d",
                     got, o0, o1, o2, e.e0, e.e1, e.e2);
        end
    endtask

    task automatic test_os_unsigned();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        exp_t e;
        clear_all();
        start_os_compute();
        os_pair(8'd3, 8'd4, 1'b1);
        checks++;
        if (a_out !== 8'd3 || !a_out_vld || b_out !== 8'd4 || !b_out_vld || psum_out_vld) begin
            failures++;
            $display("[TB] FAIL os_passthrough got a=%0d/%b b=%0d/%b psum_vld=%b required 3/1 4/1 0",
                     a_out, a_out_vld, b_out, b_out_vld, psum_out_vld);
        end
        os_pair(8'd0, 8'd0, 1'b0);
        checks++;
        if (a_out_vld || b_out_vld) begin
            failures++;
            $display("[TB] FAIL os_bubble got a_vld=%b b_vld=%b required 0 0", a_out_vld, b_out_vld);
        end
        os_pair(8'd5, 8'd6, 1'b1);
        stop_compute();
        for (int rep = 0; rep < 2; rep++) begin
            push_acc();
            run_drain(got, one, o0, o1, o2);
            e = exp_q.pop_front();
            checks++;
            if (!got || !one || o0 !== 24'd42 || {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
                failures++;
                $display("[TB] FAIL os_unsigned_drain%0d got vld=%b single=%b u24=%0d s24=%0d u16=%0d required 42 %0d %0d",
                         rep, got, one, o0, o1, o2, e.e1, e.e2);
            end
        end
    endtask

    task automatic test_os_signed();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        exp_t e;
        clear_all();
        start_os_compute();
        os_pair(8'hFD, 8'd4, 1'b1);
        os_pair(8'd2, 8'hFB, 1'b1);
        stop_compute();
        push_acc();
        run_drain(got, one, o0, o1, o2);
        e = exp_q.pop_front();
        checks++;
        if (!got || o1 !== 24'hFFFFEA || o0 !== 24'd1514 ||
            {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL os_signed_drain got u24=%0d s24=%h u16=%0d required 1514 ffffea %0d",
                     o0, o1, o2, e.e2);
        end
    endtask

    task automatic test_ws();
        exp_t e;
        bit o;
        clear_all();
        mode = 1'b1;
        load_en = 1'b1;
        tick();
        a_in = 8'd7;
        a_in_vld = 1'b1;
        tick();
        checks++;
        if (a_out !== 8'd7 || !a_out_vld || !busy) begin
            failures++;
            $display("[TB] FAIL ws_load got a=%0d vld=%b busy=%b required 7 1 1", a_out, a_out_vld, busy);
        end
        load_en = 1'b0;
        compute_en = 1'b1;
        a_in_vld = 1'b0;
        tick();
        b_in = 8'd3;
        b_in_vld = 1'b1;
        psum_in = 24'd10;
        psum_in_vld = 1'b1;
        e.e0 = model_acc(10, 8'd7, 8'd3, m_sgn[0], m_w[0], o);
        e.e1 = model_acc(10, 8'd7, 8'd3, m_sgn[1], m_w[1], o);
        e.e2 = model_acc(10, 8'd7, 8'd3, m_sgn[2], m_w[2], o);
        exp_q.push_back(e);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (!psum_out_vld || psum_out !== 24'd31 ||
            {psum_out, psum_out_s, psum_out_16} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL ws_psum got vld=%b u24=%0d s24=%0d u16=%0d required 1 31 %0d %0d",
                     psum_out_vld, psum_out, psum_out_s, psum_out_16, e.e1, e.e2);
        end
        checks++;
        if (b_out !== 8'd3 || !b_out_vld || a_out_vld) begin
            failures++;
            $display("[TB] FAIL ws_pass got b=%0d/%b a_vld=%b required 3/1 0", b_out, b_out_vld, a_out_vld);
        end
        psum_in = 24'd5;
        psum_in_vld = 1'b0;
        tick();
        checks++;
        if (psum_out_vld || psum_out_vld_s || psum_out_vld_16) begin
            failures++;
            $display("[TB] FAIL ws_no_psum_vld got vld=%b%b%b required 000",
                     psum_out_vld, psum_out_vld_s, psum_out_vld_16);
        end
        compute_en = 1'b0;
        b_in_vld = 1'b0;
        tick();
        mode = 1'b0;
        tick();
        checks++;
        if (busy || psum_out_vld) begin
            failures++;
            $display("[TB] FAIL ws_exit got busy=%b vld=%b required 0 0", busy, psum_out_vld);
        end
    endtask

    task automatic test_clear_and_ignore();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        exp_t e;
        clear_all();
        start_os_compute();
        os_pair(8'd3, 8'd4, 1'b1);
        os_pair(8'd5, 8'd6, 1'b1);
        clear_acc = 1'b1;
        os_pair(8'd9, 8'd9, 1'b1);
        clear_acc = 1'b0;
        stop_compute();
        push_acc();
        run_drain(got, one, o0, o1, o2);
        e = exp_q.pop_front();
        checks++;
        if (!got || {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL clear_beats_mac got vld=%b u24=%0d s24=%0d u16=%0d required 1 %0d %0d %0d",
                     got, o0, o1, o2, e.e0, e.e1, e.e2);
        end
        mode = 1'b0;
        load_en = 1'b1;
        tick();
        tick();
        checks++;
        if (busy || busy_s || busy_16 || a_out_vld) begin
            failures++;
            $display("[TB] FAIL load_in_os got busy=%b%b%b a_vld=%b required 000 0",
                     busy, busy_s, busy_16, a_out_vld);
        end
        load_en = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        logic [15:0] lit16;
        logic        lit_ovf;
        exp_t e;
`ifdef PE_ACC_SAT_EN
        lit16 = 16'd65535;
        lit_ovf = 1'b1;
`else
        lit16 = 16'd64514;
        lit_ovf = 1'b0;
`endif
        clear_all();
        start_os_compute();
        os_pair(8'd255, 8'd255, 1'b1);
        os_pair(8'd255, 8'd255, 1'b1);
        stop_compute();
        checks++;
        if (acc_ovf_16 !== lit_ovf || acc_ovf_16 !== m_ovf[2] || acc_ovf !== m_ovf[0]) begin
            failures++;
            $display("[TB] FAIL sat_ovf got u16=%b u24=%b required %b %b", acc_ovf_16, acc_ovf, lit_ovf, m_ovf[0]);
        end
        push_acc();
        run_drain(got, one, o0, o1, o2);
        e = exp_q.pop_front();
        checks++;
        if (!got || o2 !== lit16 || {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL sat_drain got u24=%0d s24=%0d u16=%0d required %0d %0d %0d",
                     o0, o1, o2, e.e0, e.e1, lit16);
        end
        clear_all();
        checks++;
        if (acc_ovf_16 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_ovf_clear got %b required 0", acc_ovf_16);
        end
    endtask

    task automatic test_drain_chain();
        exp_t e;
        clear_all();
        start_os_compute();
        os_pair(8'd2, 8'd3, 1'b1);
        stop_compute();
        mode = 1'b0;
        drain_en = 1'b1;
        tick();
        psum_in = 24'd123;
        psum_in_vld = 1'b1;
        push_acc();
        tick();
        e = exp_q.pop_front();
        checks++;
        if (!psum_out_vld || {psum_out, psum_out_s, psum_out_16} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL chain_own got vld=%b u24=%0d s24=%0d u16=%0d required 1 %0d %0d %0d",
                     psum_out_vld, psum_out, psum_out_s, psum_out_16, e.e0, e.e1, e.e2);
        end
        exp_q.push_back('{longint'(123), longint'(123), longint'(123)});
        drain_en = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (!psum_out_vld || {psum_out, psum_out_s, psum_out_16} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL chain_forward got vld=%b u24=%0d u16=%0d required 1 123 123",
                     psum_out_vld, psum_out, psum_out_16);
        end
        psum_in_vld = 1'b0;
        tick();
        checks++;
        if (psum_out_vld || busy) begin
            failures++;
            $display("[TB] FAIL chain_end got vld=%b busy=%b required 0 0", psum_out_vld, busy);
        end
    endtask

    task automatic test_random_os();
        bit got, one;
        logic [23:0] o0, o1;
        logic [15:0] o2;
        exp_t e;
        clear_all();
        start_os_compute();
        for (int i = 0; i < 12; i++) begin
            os_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
        stop_compute();
        push_acc();
        run_drain(got, one, o0, o1, o2);
        e = exp_q.pop_front();
        checks++;
        if (!got || !one || {o0, o1, o2} !== {24'(e.e0), 24'(e.e1), 16'(e.e2)}) begin
            failures++;
            $display("[TB] FAIL random_os got vld=%b u24=%0d s24=%0d u16=%0d required %0d %0d %0d",
                     got, o0, o1, o2, e.e0, e.e1, e.e2);
        end
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_os_unsigned();
        test_os_signed();
        test_ws();
        test_clear_and_ignore();
        test_saturation();
        test_drain_chain();
        test_random_os();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
